// File: rtl/pcs_pkg.sv
// Shared 1000BASE-X PCS definitions: synchronizer state encoding, comma
// patterns and the well-known code-groups used for alignment.
package pcs_pkg;

  typedef enum logic [1:0] {
    ST_LOSS    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_SYNC    = 2'd2
  } sync_state_e;

  // Seven-bit comma prefix (bits a..g), both running disparities.
  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam logic [9:0] D5_6      = 10'b1010010110;

  function automatic logic is_comma(input logic [9:0] cg);
    return (cg[9:3] == COMMA_P) || (cg[9:3] == COMMA_N);
  endfunction

endpackage

// File: rtl/pcs_sync_gen_if.sv
// Code-group bus between the PMA-side source and the synchronizer.
// The loss_cnt signal exists only when SYNC_STATS_EN is defined.
interface pcs_sync_gen_if;

  // Streaming contract: exactly one code-group per GTX_CLK, no backpressure.
  // cg_valid qualifies the code-group selected in the same cycle; the
  // outputs describe the code-group sampled on the previous edge.
  logic [9:0] PUDI;
  logic [9:0] TX_PUDR;
  logic       cg_valid;
  logic       signal_detect;
  logic       mr_loopback;
  logic [9:0] SUDI;
  logic       rx_even;
  logic       code_sync_status;
  logic [1:0] sync_state;
`ifdef SYNC_STATS_EN
  logic [15:0] loss_cnt;

  modport master (
    output PUDI, TX_PUDR, cg_valid, signal_detect, mr_loopback,
    input  SUDI, rx_even, code_sync_status, sync_state, loss_cnt
  );
  modport slave (
    input  PUDI, TX_PUDR, cg_valid, signal_detect, mr_loopback,
    output SUDI, rx_even, code_sync_status, sync_state, loss_cnt
  );
`else
  modport master (
    output PUDI, TX_PUDR, cg_valid, signal_detect, mr_loopback,
    input  SUDI, rx_even, code_sync_status, sync_state
  );
  modport slave (
    input  PUDI, TX_PUDR, cg_valid, signal_detect, mr_loopback,
    output SUDI, rx_even, code_sync_status, sync_state
  );
`endif

endinterface

// File: rtl/pcs_comma_detect.sv
// Combinational comma match on a 10-bit code-group; shared with the
// multi-lane aligner.
module pcs_comma_detect
  import pcs_pkg::*;
(
  input  logic [9:0] cg_i,
  output logic       comma_o
);

  assign comma_o = is_comma(cg_i);

endmodule

// File: rtl/pcs_sync_gen.sv
// 1000BASE-X PCS code-group synchronizer with loopback source mux.
// Optional SYNC_STATS_EN adds a saturating SYNC->LOSS event counter.
module pcs_sync_gen
  import pcs_pkg::*;
#(
  parameter int ACQ_COMMAS = 3,
  parameter int MAX_ERR    = 4,
  parameter int GOOD_CGS   = 4
) (
  input  logic           GTX_CLK,
  input  logic           mr_main_reset,
  pcs_sync_gen_if.slave  sif
);

  localparam int CW = $clog2(ACQ_COMMAS + 1);
  localparam int EW = $clog2(MAX_ERR + 1);
  localparam int GW = $clog2(GOOD_CGS + 1);

  sync_state_e   state_q, state_d;
  logic          rx_even_q, rx_even_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [9:0]    sudi_q;

  logic [9:0] src;
  logic       sd;
  logic       comma;
  logic       good_cg;

  assign src = sif.mr_loopback ? sif.TX_PUDR : sif.PUDI;
  assign sd  = sif.mr_loopback | sif.signal_detect;

  pcs_comma_detect u_comma (
    .cg_i    (src),
    .comma_o (comma)
  );

  // rx_even still holds the parity of the previous code-group, so a comma
  // seen while it is 1 sits at an odd position.
  assign good_cg = sif.cg_valid && !(comma && rx_even_q);

  always_comb begin
    state_d     = state_q;
    rx_even_d   = ~rx_even_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;

    if (!sd) begin
      state_d     = ST_LOSS;
      comma_cnt_d = '0;
      err_cnt_d   = '0;
      good_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_LOSS: begin
          if (comma) begin
            rx_even_d = 1'b1;
            if (ACQ_COMMAS == 1) begin
              state_d = ST_SYNC;
            end else begin
              state_d     = ST_ACQUIRE;
              comma_cnt_d = CW'(1);
            end
          end
        end

        ST_ACQUIRE: begin
          if (!sif.cg_valid || (comma && rx_even_q)) begin
            state_d     = ST_LOSS;
            comma_cnt_d = '0;
          end else if (comma) begin
            if ((int'(comma_cnt_q) + 1) >= ACQ_COMMAS) begin
              state_d     = ST_SYNC;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
              good_cnt_d  = '0;
            end else begin
              comma_cnt_d = comma_cnt_q + CW'(1);
            end
          end
        end

        ST_SYNC: begin
          if (!good_cg) begin
            good_cnt_d = '0;
            if ((int'(err_cnt_q) + 1) >= MAX_ERR) begin
              state_d   = ST_LOSS;
              err_cnt_d = '0;
            end else begin
              err_cnt_d = err_cnt_q + EW'(1);
            end
          end else if (err_cnt_q != '0) begin
            // Each run of GOOD_CGS good code-groups forgives one error.
            if ((int'(good_cnt_q) + 1) >= GOOD_CGS) begin
              err_cnt_d  = err_cnt_q - EW'(1);
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GW'(1);
            end
          end else begin
            good_cnt_d = '0;
          end
        end

        default: begin
          state_d     = ST_LOSS;
          comma_cnt_d = '0;
          err_cnt_d   = '0;
          good_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q     <= ST_LOSS;
      rx_even_q   <= 1'b0;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      good_cnt_q  <= '0;
      sudi_q      <= 10'h000;
    end else begin
      state_q     <= state_d;
      rx_even_q   <= rx_even_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      sudi_q      <= src;
    end
  end

  assign sif.SUDI             = sudi_q;
  assign sif.rx_even          = rx_even_q;
  assign sif.code_sync_status = (state_q == ST_SYNC);
  assign sif.sync_state       = state_q;

`ifdef SYNC_STATS_EN
  logic [15:0] loss_cnt_q;

  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      loss_cnt_q <= 16'h0000;
    end else if ((state_q == ST_SYNC) && (state_d == ST_LOSS) &&
                 (loss_cnt_q != 16'hFFFF)) begin
      loss_cnt_q <= loss_cnt_q + 16'h0001;
    end
  end

  assign sif.loss_cnt = loss_cnt_q;
`endif

endmodule
